// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver.
//   state_t     : receiver FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   FRAME_BITS  : number of payload bits captured per frame (b1..b5 + parity)
package serial_frame_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   localparam int FRAME_BITS = 6;

endpackage : serial_frame_rx_pkg

// File: rtl/serial_frame_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a falling-edge
// detector on the synchronised value.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (all flops reset to line-idle 1)
//   rx    in  raw asynchronous serial line
//   rx_s  out synchronised line value
//   fall  out high for one cycle when rx_s goes 1 -> 0
module rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rx_s,
   output logic fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= rx;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign rx_s = r_sync;
   assign fall = r_prev & ~r_sync;

endmodule : rx_sync

// File: rtl/serial_frame_rx.sv
// Deserialises a UART-style frame (start, b1..b5, parity, stop) from one serial
// line and holds the last good frame on registered outputs for the downstream
// parity checker / decoder. Parity is forwarded unchecked.
// Ports:
//   clk          in  system clock, rising edge
//   rst_n        in  asynchronous active-low reset
//   rx           in  asynchronous serial line, idle high
//   b1..b5       out received data bits, b1 first on the line
//   b_par        out received parity bit
//   frame_valid  out 1-cycle pulse when b1..b5/b_par update
//   frame_err    out 1-cycle pulse when the stop bit is sampled low
//   busy         out high whenever the FSM is not idle
//   dbg_state    out current FSM state, for observation only
module serial_frame_rx
   import serial_frame_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   rx,
   output logic   b1,
   output logic   b2,
   output logic   b3,
   output logic   b4,
   output logic   b5,
   output logic   b_par,
   output logic   frame_valid,
   output logic   frame_err,
   output logic   busy,
   output state_t dbg_state
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_IDX = 3'(FRAME_BITS - 1);

   logic                  w_rx_s;
   logic                  w_fall;

   state_t                r_state;
   state_t                w_next_state;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_next;
   logic [2:0]            r_bit_idx;
   logic [2:0]            w_idx_next;
   logic [FRAME_BITS-1:0] r_shift;
   logic [FRAME_BITS-1:0] w_shift_next;
   logic [FRAME_BITS-1:0] r_data;
   logic                  r_frame_valid;
   logic                  r_frame_err;
   logic                  w_load;
   logic                  w_err;

   rx_sync u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .rx_s  (w_rx_s),
      .fall  (w_fall)
   );

   // Handshake: there is no back-pressure. frame_valid / frame_err are
   // single-cycle strobes; b1..b5/b_par are stable from the frame_valid cycle
   // until the next frame_valid or reset.
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_bit_idx;
      w_shift_next = r_shift;
      w_load       = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_next = '0;
            if (w_fall) begin
               w_next_state = ST_START;
            end
         end
         ST_START: begin
            // Re-check the line at mid start bit to reject short glitches.
            if (r_cnt == HALF_M1) begin
               w_cnt_next = '0;
               if (!w_rx_s) begin
                  w_next_state = ST_DATA;
                  w_idx_next   = '0;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_DATA: begin
            // Counter was re-zeroed at mid start bit, so every full bit
            // period from here lands on mid-bit.
            if (r_cnt == FULL_M1) begin
               w_cnt_next              = '0;
               w_shift_next[r_bit_idx] = w_rx_s;
               if (r_bit_idx == LAST_IDX) begin
                  w_next_state = ST_STOP;
               end else begin
                  w_idx_next = r_bit_idx + 1'b1;
               end
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_STOP: begin
            // Return to IDLE at mid stop bit so a back-to-back start edge
            // half a bit later is still caught.
            if (r_cnt == FULL_M1) begin
               w_cnt_next   = '0;
               w_next_state = ST_IDLE;
               if (w_rx_s) begin
                  w_load = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_bit_idx     <= '0;
         r_shift       <= '0;
         r_data        <= '0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_cnt         <= w_cnt_next;
         r_bit_idx     <= w_idx_next;
         r_shift       <= w_shift_next;
         r_frame_valid <= w_load;
         r_frame_err   <= w_err;
         if (w_load) begin
            r_data <= r_shift;
         end
      end
   end

   // Shift register bit 0 holds the first data bit on the line (b1).
   assign b1          = r_data[0];
   assign b2          = r_data[1];
   assign b3          = r_data[2];
   assign b4          = r_data[3];
   assign b5          = r_data[4];
   assign b_par       = r_data[5];
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign busy        = (r_state != ST_IDLE);
   assign dbg_state   = r_state;

endmodule : serial_frame_rx
